cpu_bus_serializer: RTL

//  Parametrised bridge between the CPU core's wide parallel memory port and narrow chip pins.

---
 rtl/cpu_bus_serializer_if.sv | 34 +++
 rtl/cpu_bus_serializer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_serializer_if.sv
`timescale 1ns/1ps
// cpu_bus_serializer_if: groups the CPU-side request/response signals and the
// pin-side address/data/ready signals of the CPU bus serializer.
// The slave view belongs to the serializer; the master view belongs to whatever
// drives the CPU port and models the pads.
interface cpu_bus_serializer_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int PIN_W  = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_err;
  logic [DATA_W-1:0] cpu_rdata;
  logic              busy;
  logic [PIN_W-1:0]  pin_out;
  logic [PIN_W-1:0]  pio_out;
  logic [PIN_W-1:0]  pio_oe;
  logic [PIN_W-1:0]  pio_in;
  logic              ext_rdy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, pio_in, ext_rdy,
    output cpu_ack, cpu_err, cpu_rdata, busy, pin_out, pio_out, pio_oe
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, pio_in, ext_rdy,
    input  cpu_ack, cpu_err, cpu_rdata, busy, pin_out, pio_out, pio_oe
  );
endinterface

// File: rtl/cpu_bus_serializer.sv
`timescale 1ns/1ps
// cpu_bus_serializer: bridges the CPU's wide parallel memory port onto narrow
// chip pins. A transaction sends the address LSB beat first, then (for writes)
// the data, then a one-beat command, waits for ext_rdy (with optional timeout),
// captures read data beat by beat, and finishes with a one-cycle cpu_ack.
// All outputs decode registered state only; no input reaches an output
// combinationally.
module cpu_bus_serializer #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int PIN_W    = 8,
  parameter int WAIT_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_bus_serializer_if.slave  bus
);

  localparam int AB   = ADDR_W / PIN_W;
  localparam int DB   = DATA_W / PIN_W;
  localparam int MAXB = (AB > DB) ? AB : DB;
  localparam int BW   = ($clog2(MAXB) > 0) ? $clog2(MAXB) : 1;
  localparam int WW   = ($clog2(WAIT_MAX + 1) > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [BW-1:0] AB_LAST   = BW'(AB - 1);
  localparam logic [BW-1:0] DB_LAST   = BW'(DB - 1);
  localparam logic [WW-1:0] WAIT_LAST = (WAIT_MAX > 0) ? WW'(WAIT_MAX - 1) : '0;

  // Geometry that cannot be serialised cleanly is rejected at elaboration.
  if (PIN_W < 2) begin : g_bad_pin_w
    $error("cpu_bus_serializer: PIN_W must be at least 2");
  end
  if ((ADDR_W % PIN_W) != 0) begin : g_bad_addr_w
    $error("cpu_bus_serializer: ADDR_W must be a multiple of PIN_W");
  end
  if ((DATA_W % PIN_W) != 0) begin : g_bad_data_w
    $error("cpu_bus_serializer: DATA_W must be a multiple of PIN_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_CMD,
    S_WAIT,
    S_RDATA,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q;
  logic [WW-1:0]     wait_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_buf_q;
  logic [DATA_W-1:0] rd_merged;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              wait_expired;
  logic              timeout_hit;
  logic [PIN_W-1:0]  pin_d;
  logic [PIN_W-1:0]  pio_d;
  logic [PIN_W-1:0]  oe_d;

  // Timeout fires on the WAIT_MAX-th consecutive not-ready cycle; ready wins.
  assign wait_expired = (WAIT_MAX != 0) && (wait_q == WAIT_LAST) && !bus.ext_rdy;
  assign timeout_hit  = (state_q == S_WAIT) && wait_expired;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode for the transaction sequence.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.cpu_req) state_d = S_ADDR;
      S_ADDR:  if (beat_q == AB_LAST) state_d = we_q ? S_WDATA : S_CMD;
      S_WDATA: if (beat_q == DB_LAST) state_d = S_CMD;
      S_CMD:   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.ext_rdy)       state_d = we_q ? S_DONE : S_RDATA;
        else if (wait_expired) state_d = S_DONE;
      end
      S_RDATA: if (beat_q == DB_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat counter restarts on every state change; wait counter restarts in CMD
  // so it is zero on WAIT entry and counts only not-ready WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      wait_q <= '0;
    end else begin
      if (state_d != state_q) beat_q <= '0;
      else if (state_q inside {S_ADDR, S_WDATA, S_RDATA}) beat_q <= beat_q + 1'b1;

      if (state_q == S_CMD) wait_q <= '0;
      else if (state_q == S_WAIT && !bus.ext_rdy) wait_q <= wait_q + 1'b1;
    end
  end

  // Shadow the request on acceptance; CPU inputs are ignored until the next IDLE.
  // NOTE: the shadow registers are reset even though they are reloaded before
  // use, so the pins decode to a known zero from reset onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == S_IDLE && bus.cpu_req) begin
      we_q    <= bus.cpu_we;
      addr_q  <= bus.cpu_addr;
      wdata_q <= bus.cpu_wdata;
    end
  end

  // Read buffer with the current pio_in beat merged in at its lane.
  always_comb begin
    rd_merged = rd_buf_q;
    rd_merged[beat_q*PIN_W +: PIN_W] = bus.pio_in;
  end

  // Collect read beats; publish to cpu_rdata only at completion so the CPU view
  // stays stable between acks. Timeout clears it; writes leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_buf_q <= '0;
      rdata_q  <= '0;
    end else if (state_q == S_RDATA) begin
      rd_buf_q <= rd_merged;
      if (beat_q == DB_LAST) rdata_q <= rd_merged;
    end else if (timeout_hit) begin
      rdata_q <= '0;
    end
  end

  // Error flag is decided on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (state_d == S_DONE && state_q != S_DONE) err_q <= timeout_hit;
  end

  // Pin decode from state, beat counter and shadow registers.
  always_comb begin
    pin_d = '0;
    pio_d = '0;
    oe_d  = '0;
    case (state_q)
      S_ADDR: pin_d = addr_q[beat_q*PIN_W +: PIN_W];
      S_WDATA: begin
        pio_d = wdata_q[beat_q*PIN_W +: PIN_W];
        oe_d  = '1;
      end
      S_CMD: begin
        pin_d[1] = we_q;
        pin_d[0] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pin_out   = pin_d;
  assign bus.pio_out   = pio_d;
  assign bus.pio_oe    = oe_d;
  assign bus.cpu_ack   = (state_q == S_DONE);
  assign bus.cpu_err   = (state_q == S_DONE) && err_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
